// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/response bundle between a requesting datapath
// and the bit-serial adder controller.
//   start/op_a/op_b/cin : request side, driven by the requester (master)
//   busy/done/result/cout: response side, driven by the controller (slave)
//   ovf                  : signed overflow, only when SERIAL_ADD_OVF_EN is defined
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, op_a, op_b, cin,
                    input  busy, done, result, cout, ovf);
    modport slave  (input  start, op_a, op_b, cin,
                    output busy, done, result, cout, ovf);
`else
    modport master (output start, op_a, op_b, cin,
                    input  busy, done, result, cout);
    modport slave  (input  start, op_a, op_b, cin,
                    output busy, done, result, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder. One shared full_addd cell is
// stepped LSB first, one bit per clock, with a registered carry loop.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-high (wins over start)
//   bus   : serial_add_ctrl_if.slave -- start/op_a/op_b/cin in,
//           busy/done/result/cout (and ovf) out, all outputs registered
// Optional feature: define SERIAL_ADD_OVF_EN to add the two's-complement
// overflow output bus.ovf, held alongside result.

// Single-bit full adder cell shared across all bit positions.
module full_addd (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_add_ctrl_if.slave      bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Holds the WIDTH-1 sum bits collected so far; the last bit comes
    // straight from the adder on the completion cycle.
    logic [WIDTH-2:0]   s_q, s_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               fa_sum;
    logic               fa_carry;
    logic [WIDTH-1:0]   sum_full;

    full_addd u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Sum register after this cycle's bit enters at the MSB.
    assign sum_full = {fa_sum, s_q};

    // Next-state and datapath next values.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                s_d   = sum_full[WIDTH-1:1];
                c_d   = fa_carry;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    result_d = sum_full;
                    cout_d   = fa_carry;
`ifdef SERIAL_ADD_OVF_EN
                    // c_q is the carry into the MSB on this cycle.
                    ovf_d    = c_q ^ fa_carry;
`endif
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule
